coinc_acq_ctrl: RTL and testbench

Acquisition sequencer for the coincidence counter bank. It clears the pair counters, gates them for a programmed window of clock cycles, and snapshots the NPAIRS = NCHAN*(NCHAN-1)/2 counts. It then streams the snapshot out, one pair per transfer, over a valid/ready interface. It sits between the host/readout logic and the detector datapath, and drives that datapath's clear and enable inputs.

---
 rtl/coinc_acq_ctrl_pkg.sv | 37 +++
 rtl/coinc_acq_ctrl_timer.sv | 45 ++++
 rtl/coinc_acq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_coinc_acq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coinc_acq_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coinc_acq_ctrl_pkg                                               |
// | Shared types and helpers for the coincidence acquisition slice:  |
// | sequencer state encoding and pair-count / pair-index mapping.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package coinc_acq_ctrl_pkg;

  // Sequencer states. The explicit width keeps the register 3 bits wide.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQ     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_SNAP    = 3'd4,
    ST_READOUT = 3'd5
  } acq_state_e;

  // Number of unordered channel pairs.
  function automatic int npairs(input int nchan);
    return nchan * (nchan - 1) / 2;
  endfunction

  // Flat index of pair (i,j), i<j, in the order (0,1),(0,2)..(0,N-1),(1,2)..
  // The detector packs its counters with the same mapping.
  function automatic int pair_index(input int nchan, input int i, input int j);
    return i * (2 * nchan - i - 1) / 2 + (j - i - 1);
  endfunction

  // Width of an index that can address n entries (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coinc_acq_ctrl_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | acq_window_timer                                                 |
// | Loadable down-counter with terminal count (count == 1). Timing   |
// | for both the acquisition window and the drain tail.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module acq_window_timer #(
  parameter int WBITS = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load_i,
  input  logic [WBITS-1:0] LoadVal_i,
  input  logic             Dec_i,
  output logic             Tc_o
);

  logic [WBITS-1:0] count_q;
  logic [WBITS-1:0] count_d;

  // Load wins over decrement; the counter parks at zero rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (Load_i) begin
      count_d = LoadVal_i;
    end else if (Dec_i && (count_q != '0)) begin
      count_d = count_q - WBITS'(1);
    end
  end

  // Counter register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count marks the last cycle of the phase being timed.
  assign Tc_o = (count_q == WBITS'(1));

endmodule
`default_nettype wire

// File: rtl/coinc_acq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coinc_acq_ctrl                                                   |
// | Acquisition sequencer: clears and gates the pair counters for a  |
// | programmed window plus drain tail, snapshots all pair counts and |
// | streams them out one pair per valid/ready transfer.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module coinc_acq_ctrl
  import coinc_acq_ctrl_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int NBITS = 4,
  parameter int WBITS = 16,
  parameter int DRAIN = 3
) (
  input  logic                                    Clk,
  input  logic                                    Rst_n,
  input  logic                                    Start_i,
  input  logic                                    Abort_i,
  input  logic                                    Continuous_i,
  input  logic [WBITS-1:0]                        Window_i,
  input  logic [NBITS*npairs(NCHAN)-1:0]          Counts_i,
  output logic                                    CntClr_o,
  output logic                                    CntEn_o,
  output logic                                    OutValid_o,
  input  logic                                    OutReady_i,
  output logic [idx_width(npairs(NCHAN))-1:0]     OutPair_o,
  output logic [NBITS-1:0]                        OutCount_o,
  output logic                                    OutLast_o,
  output logic                                    Busy_o,
  output logic                                    Sat_o
);

  localparam int               NPAIRS    = npairs(NCHAN);
  localparam int               PW        = idx_width(NPAIRS);
  localparam logic [PW-1:0]    LAST_IDX  = PW'(NPAIRS - 1);
  localparam logic [WBITS-1:0] DRAIN_LEN = WBITS'(DRAIN);

  acq_state_e                state_q;
  acq_state_e                state_d;
  logic [PW-1:0]             idx_q;
  logic [PW-1:0]             idx_d;
  logic                      cntclr_q;
  logic                      cnten_q;
  logic                      valid_q;
  logic                      busy_q;
  logic                      sat_q;
  logic                      sat_d;
  logic [NBITS*NPAIRS-1:0]   shadow_q;

  logic                      tmr_load;
  logic [WBITS-1:0]          tmr_val;
  logic                      tmr_dec;
  logic                      tmr_tc;

  logic [NPAIRS-1:0]         pair_full;
  logic [NBITS-1:0]          shadow_word [NPAIRS];
  logic                      any_full;
  logic                      handshake;
  logic                      is_last;

  // Per-pair views: saturation detect on live counts, word select on snapshot.
  for (genvar p = 0; p < NPAIRS; p++) begin : g_pair
    assign pair_full[p]   = &Counts_i[p*NBITS +: NBITS];
    assign shadow_word[p] = shadow_q[p*NBITS +: NBITS];
  end

  assign any_full  = |pair_full;
  // valid_q is high exactly while the state register holds READOUT.
  assign handshake = valid_q & OutReady_i;
  assign is_last   = (idx_q == LAST_IDX);
  assign tmr_dec   = (state_q == ST_ACQ) || (state_q == ST_DRAIN);

  acq_window_timer #(
    .WBITS (WBITS)
  ) u_timer (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Load_i    (tmr_load),
    .LoadVal_i (tmr_val),
    .Dec_i     (tmr_dec),
    .Tc_o      (tmr_tc)
  );

  // Next-state, timer-load and readout-index decisions; Abort overrides all.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = Window_i;
    unique case (state_q)
      ST_IDLE: begin
        if (Start_i) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // Window is sampled here; an empty window jumps straight to the tail.
        tmr_load = 1'b1;
        if (Window_i != '0) begin
          state_d = ST_ACQ;
        end else if (DRAIN != 0) begin
          state_d = ST_DRAIN;
          tmr_val = DRAIN_LEN;
        end else begin
          state_d = ST_SNAP;
        end
      end
      ST_ACQ: begin
        if (tmr_tc) begin
          if (DRAIN != 0) begin
            state_d  = ST_DRAIN;
            tmr_load = 1'b1;
            tmr_val  = DRAIN_LEN;
          end else begin
            state_d = ST_SNAP;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_tc) begin
          state_d = ST_SNAP;
        end
      end
      ST_SNAP: begin
        state_d = ST_READOUT;
        idx_d   = '0;
      end
      ST_READOUT: begin
        if (handshake) begin
          if (is_last) begin
            state_d = Continuous_i ? ST_CLEAR : ST_IDLE;
          end else begin
            idx_d = idx_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (Abort_i) begin
      state_d = ST_IDLE;
    end
  end

  // State register with outputs registered from the next state, so every
  // control output lines up with the state it belongs to.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cntclr_q <= 1'b0;
      cnten_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cntclr_q <= (state_d == ST_CLEAR);
      cnten_q  <= (state_d == ST_ACQ) || (state_d == ST_DRAIN);
      valid_q  <= (state_d == ST_READOUT);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  // Sticky saturation: cleared by CLEAR, set by an all-ones count while gated.
  always_comb begin
    sat_d = sat_q;
    if (state_q == ST_CLEAR) begin
      sat_d = 1'b0;
    end else if (tmr_dec && any_full) begin
      sat_d = 1'b1;
    end
  end

  // Saturation flag register; survives Abort, only reset or CLEAR drop it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  // Snapshot of every pair count, taken during the single SNAP cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shadow_q <= '0;
    end else if (state_q == ST_SNAP) begin
      shadow_q <= Counts_i;
    end
  end

  // Readout fields are forced to zero whenever no word is being offered.
  assign CntClr_o   = cntclr_q;
  assign CntEn_o    = cnten_q;
  assign OutValid_o = valid_q;
  assign OutPair_o  = valid_q ? idx_q : '0;
  assign OutCount_o = valid_q ? shadow_word[idx_q] : '0;
  assign OutLast_o  = valid_q & is_last;
  assign Busy_o     = busy_q;
  assign Sat_o      = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_coinc_acq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_coinc_acq_ctrl                                                |
// | Directed bench: cycle table for a short run, then hand sequences |
// | for window length, backpressure, saturation, continuous mode,    |
// | abort and mid-run reset.                                         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_coinc_acq_ctrl;
  import coinc_acq_ctrl_pkg::*;

  localparam int NCHAN  = 4;
  localparam int NBITS  = 4;
  localparam int WBITS  = 16;
  localparam int DRAIN  = 3;
  localparam int NPAIRS = npairs(NCHAN);
  localparam int PW     = idx_width(NPAIRS);

  logic                    Clk = 1'b0;
  logic                    Rst_n = 1'b0;
  logic                    Start_i = 1'b0;
  logic                    Abort_i = 1'b0;
  logic                    Continuous_i = 1'b0;
  logic [WBITS-1:0]        Window_i = '0;
  logic [NBITS*NPAIRS-1:0] Counts_i = '0;
  logic                    OutReady_i = 1'b0;
  logic                    CntClr_o;
  logic                    CntEn_o;
  logic                    OutValid_o;
  logic [PW-1:0]           OutPair_o;
  logic [NBITS-1:0]        OutCount_o;
  logic                    OutLast_o;
  logic                    Busy_o;
  logic                    Sat_o;

  int errors = 0;
  int checks = 0;

  coinc_acq_ctrl #(
    .NCHAN (NCHAN),
    .NBITS (NBITS),
    .WBITS (WBITS),
    .DRAIN (DRAIN)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Start_i      (Start_i),
    .Abort_i      (Abort_i),
    .Continuous_i (Continuous_i),
    .Window_i     (Window_i),
    .Counts_i     (Counts_i),
    .CntClr_o     (CntClr_o),
    .CntEn_o      (CntEn_o),
    .OutValid_o   (OutValid_o),
    .OutReady_i   (OutReady_i),
    .OutPair_o    (OutPair_o),
    .OutCount_o   (OutCount_o),
    .OutLast_o    (OutLast_o),
    .Busy_o       (Busy_o),
    .Sat_o        (Sat_o)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (act=timeout req=finish)");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge Clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic                    start;
    logic                    ready;
    logic [NBITS*NPAIRS-1:0] counts;
    logic                    e_clr;
    logic                    e_en;
    logic                    e_val;
    logic [PW-1:0]           e_pair;
    logic [NBITS-1:0]        e_cnt;
    logic                    e_last;
    logic                    e_busy;
  } vec_t;

  function automatic vec_t mk(input int st, input int rd, input logic [23:0] cnt,
                              input int clr, input int en, input int val,
                              input int pair, input int c, input int last, input int busy);
    vec_t v;
    v.start  = (st != 0);
    v.ready  = (rd != 0);
    v.counts = cnt;
    v.e_clr  = (clr != 0);
    v.e_en   = (en != 0);
    v.e_val  = (val != 0);
    v.e_pair = PW'(pair);
    v.e_cnt  = NBITS'(c);
    v.e_last = (last != 0);
    v.e_busy = (busy != 0);
    return v;
  endfunction

  // Results of the most recent run_once.
  int r_clr, r_en, r_first_en, r_first_v, r_words, r_done;

  // One full run with OutReady held high; optional all-ones pulse on pair 2.
  task automatic run_once(input logic [WBITS-1:0] win, input bit inj);
    Window_i   = win;
    OutReady_i = 1'b1;
    Start_i    = 1'b1;
    step();
    Start_i    = 1'b0;
    r_clr = 0; r_en = 0; r_first_en = -1; r_first_v = -1; r_words = 0; r_done = 0;
    for (int n = 0; n < 100 && r_done == 0; n++) begin
      Counts_i = (inj && n == 2) ? 24'h000F00 : 24'h000000;
      if (CntClr_o) r_clr++;
      if (CntEn_o) begin
        r_en++;
        if (r_first_en < 0) r_first_en = n;
      end
      if (OutValid_o) begin
        if (r_first_v < 0) r_first_v = n;
        chk("run_pair", 32'(OutPair_o), 32'(r_words));
        chk("run_last", 32'(OutLast_o), 32'(r_words == NPAIRS - 1));
        chk("run_count", 32'(OutCount_o), 32'd0);
        if (OutLast_o) r_done = 1;
        r_words++;
      end
      step();
    end
    Counts_i = '0;
    chk("run_completed", 32'(r_done), 32'd1);
  endtask

  task automatic wait_last(input string nm);
    for (int n = 0; n < 200; n++) begin
      if (OutValid_o && OutLast_o) break;
      step();
    end
    chk(nm, 32'(OutValid_o && OutLast_o), 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    for (int n = 0; n < 200; n++) begin
      if (OutValid_o) break;
      step();
    end
    chk(nm, 32'(OutValid_o), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    OutReady_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (!Busy_o) break;
      step();
    end
    chk(nm, 32'(Busy_o), 32'd0);
  endtask

  vec_t                    vt[16];
  logic [NBITS*NPAIRS-1:0] bp;
  int                      got, fin;
  logic                    rdy, pv, pr;
  logic [PW-1:0]           pp;
  logic [NBITS-1:0]        pc;

  initial begin
    // Short run: Window=2, DRAIN=3, one stall in readout.
    vt[0]  = mk(1, 0, 24'h000000, 1, 0, 0, 0, 0,  0, 1);
    vt[1]  = mk(0, 0, 24'h000000, 0, 1, 0, 0, 0,  0, 1);
    vt[2]  = mk(0, 0, 24'h000000, 0, 1, 0, 0, 0,  0, 1);
    vt[3]  = mk(0, 0, 24'h000000, 0, 1, 0, 0, 0,  0, 1);
    vt[4]  = mk(0, 0, 24'h000000, 0, 1, 0, 0, 0,  0, 1);
    vt[5]  = mk(0, 0, 24'h000000, 0, 1, 0, 0, 0,  0, 1);
    vt[6]  = mk(0, 0, 24'h111111, 0, 0, 0, 0, 0,  0, 1);
    vt[7]  = mk(0, 0, 24'hDB9753, 0, 0, 1, 0, 3,  0, 1);
    vt[8]  = mk(0, 1, 24'h222222, 0, 0, 1, 1, 5,  0, 1);
    vt[9]  = mk(0, 0, 24'h222222, 0, 0, 1, 1, 5,  0, 1);
    vt[10] = mk(0, 1, 24'h222222, 0, 0, 1, 2, 7,  0, 1);
    vt[11] = mk(0, 1, 24'h222222, 0, 0, 1, 3, 9,  0, 1);
    vt[12] = mk(0, 1, 24'h222222, 0, 0, 1, 4, 11, 0, 1);
    vt[13] = mk(0, 1, 24'h222222, 0, 0, 1, 5, 13, 1, 1);
    vt[14] = mk(0, 1, 24'h222222, 0, 0, 0, 0, 0,  0, 0);
    vt[15] = mk(0, 0, 24'h000000, 0, 0, 0, 0, 0,  0, 0);

    // Reset state.
    step(); step();
    chk("rst_clr",   32'(CntClr_o),   32'd0);
    chk("rst_en",    32'(CntEn_o),    32'd0);
    chk("rst_valid", 32'(OutValid_o), 32'd0);
    chk("rst_busy",  32'(Busy_o),     32'd0);
    chk("rst_sat",   32'(Sat_o),      32'd0);
    Rst_n = 1'b1;
    step();

    // Table-driven cycle vectors.
    Window_i = 16'd2;
    for (int v = 0; v < 16; v++) begin
      Start_i    = vt[v].start;
      OutReady_i = vt[v].ready;
      Counts_i   = vt[v].counts;
      step();
      chk($sformatf("vec%0d_clr", v),   32'(CntClr_o),   32'(vt[v].e_clr));
      chk($sformatf("vec%0d_en", v),    32'(CntEn_o),    32'(vt[v].e_en));
      chk($sformatf("vec%0d_valid", v), 32'(OutValid_o), 32'(vt[v].e_val));
      chk($sformatf("vec%0d_pair", v),  32'(OutPair_o),  32'(vt[v].e_pair));
      chk($sformatf("vec%0d_count", v), 32'(OutCount_o), 32'(vt[v].e_cnt));
      chk($sformatf("vec%0d_last", v),  32'(OutLast_o),  32'(vt[v].e_last));
      chk($sformatf("vec%0d_busy", v),  32'(Busy_o),     32'(vt[v].e_busy));
      chk($sformatf("vec%0d_sat", v),   32'(Sat_o),      32'd0);
    end
    Start_i = 1'b0; Counts_i = '0;

    // Basic run: Window=10 -> 1 clear cycle, 13 enable cycles, 6 words.
    run_once(16'd10, 1'b0);
    chk("basic_clr_cycles", 32'(r_clr), 32'd1);
    chk("basic_en_cycles",  32'(r_en), 32'd13);
    chk("basic_first_en",   32'(r_first_en), 32'd1);
    chk("basic_first_valid", 32'(r_first_v), 32'd15);
    chk("basic_words",      32'(r_words), 32'd6);
    chk("basic_busy_after", 32'(Busy_o), 32'd0);
    chk("basic_sat",        32'(Sat_o), 32'd0);

    // Backpressure: pair p carries p+1, ready alternates.
    bp = '0;
    for (int i = 0; i < NCHAN - 1; i++)
      for (int j = i + 1; j < NCHAN; j++)
        bp[pair_index(NCHAN, i, j)*NBITS +: NBITS] = NBITS'(pair_index(NCHAN, i, j) + 1);
    Counts_i = bp; Window_i = 16'd1; OutReady_i = 1'b0;
    Start_i = 1'b1; step(); Start_i = 1'b0;
    got = 0; fin = 0; rdy = 1'b1; pv = 1'b0; pr = 1'b0; pp = '0; pc = '0;
    for (int n = 0; n < 100 && fin == 0; n++) begin
      if (OutValid_o) begin
        Counts_i = '0;
        if (pv && !pr) begin
          chk("bp_hold_pair", 32'(OutPair_o), 32'(pp));
          chk("bp_hold_count", 32'(OutCount_o), 32'(pc));
        end
        rdy = ~rdy;
        OutReady_i = rdy;
        if (rdy) begin
          chk("bp_value", 32'(OutCount_o), 32'(got + 1));
          chk("bp_pair", 32'(OutPair_o), 32'(got));
          got++;
          if (OutLast_o) fin = 1;
        end
      end else begin
        OutReady_i = 1'b0;
      end
      pv = OutValid_o; pr = OutReady_i; pp = OutPair_o; pc = OutCount_o;
      step();
    end
    chk("bp_words", 32'(got), 32'd6);
    chk("bp_idle_after", 32'(Busy_o), 32'd0);

    // Window=0: enable only for the drain tail.
    run_once(16'd0, 1'b0);
    chk("w0_clr_cycles", 32'(r_clr), 32'd1);
    chk("w0_en_cycles",  32'(r_en), 32'd3);
    chk("w0_first_en",   32'(r_first_en), 32'd1);
    chk("w0_first_valid", 32'(r_first_v), 32'd5);

    // Saturation: sticky through readout, cleared by the next CLEAR.
    run_once(16'd5, 1'b1);
    chk("sat_after_run", 32'(Sat_o), 32'd1);
    step();
    chk("sat_idle_hold", 32'(Sat_o), 32'd1);
    Window_i = 16'd5; Start_i = 1'b1; step(); Start_i = 1'b0;
    step();
    chk("sat_cleared", 32'(Sat_o), 32'd0);
    chk("sat_next_en", 32'(CntEn_o), 32'd1);
    wait_idle("sat_run_end");

    // Continuous mode: CLEAR right after the last handshake.
    Continuous_i = 1'b1; Window_i = 16'd5; OutReady_i = 1'b1;
    Start_i = 1'b1; step(); Start_i = 1'b0;
    wait_last("cont_last1");
    step();
    chk("cont_clr_next", 32'(CntClr_o), 32'd1);
    chk("cont_busy",     32'(Busy_o), 32'd1);
    Continuous_i = 1'b0;
    wait_last("cont_last2");
    step();
    chk("cont_stop_busy", 32'(Busy_o), 32'd0);
    chk("cont_stop_clr",  32'(CntClr_o), 32'd0);

    // Abort during ACQ, with an ignored Start first.
    Window_i = 16'd20; Start_i = 1'b1; step(); Start_i = 1'b0;
    step(); step();
    chk("abort_acq_en", 32'(CntEn_o), 32'd1);
    Start_i = 1'b1; step(); Start_i = 1'b0;
    chk("ign_start_clr", 32'(CntClr_o), 32'd0);
    chk("ign_start_en",  32'(CntEn_o), 32'd1);
    Abort_i = 1'b1; step(); Abort_i = 1'b0;
    chk("abort_acq_busy", 32'(Busy_o), 32'd0);
    chk("abort_acq_en0",  32'(CntEn_o), 32'd0);

    // Abort during READOUT while stalled.
    Window_i = 16'd1; OutReady_i = 1'b0; Start_i = 1'b1; step(); Start_i = 1'b0;
    wait_valid("abort_rd_wait");
    step();
    chk("abort_rd_stall_valid", 32'(OutValid_o), 32'd1);
    chk("abort_rd_stall_pair",  32'(OutPair_o), 32'd0);
    Abort_i = 1'b1; step(); Abort_i = 1'b0;
    chk("abort_rd_valid", 32'(OutValid_o), 32'd0);
    chk("abort_rd_busy",  32'(Busy_o), 32'd0);

    // Start together with Abort in IDLE stays idle; a plain Start then works.
    Start_i = 1'b1; Abort_i = 1'b1; step(); Start_i = 1'b0; Abort_i = 1'b0;
    chk("start_abort_busy", 32'(Busy_o), 32'd0);
    chk("start_abort_clr",  32'(CntClr_o), 32'd0);
    Window_i = 16'd2; Start_i = 1'b1; step(); Start_i = 1'b0;
    chk("restart_clr", 32'(CntClr_o), 32'd1);
    wait_idle("restart_end");

    // Reset in the middle of ACQ after Sat has been set.
    Window_i = 16'd20; Start_i = 1'b1; step(); Start_i = 1'b0;
    step();
    Counts_i = 24'hF00000; step(); Counts_i = '0; step();
    chk("mrst_pre_sat", 32'(Sat_o), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("mrst_en",    32'(CntEn_o), 32'd0);
    chk("mrst_busy",  32'(Busy_o), 32'd0);
    chk("mrst_sat",   32'(Sat_o), 32'd0);
    chk("mrst_valid", 32'(OutValid_o), 32'd0);
    chk("mrst_clr",   32'(CntClr_o), 32'd0);
    step();
    Rst_n = 1'b1;
    step();
    chk("mrst_idle", 32'(Busy_o), 32'd0);
    Window_i = 16'd3; Start_i = 1'b1; step(); Start_i = 1'b0;
    chk("mrst_start_clr", 32'(CntClr_o), 32'd1);
    step();
    chk("mrst_start_en", 32'(CntEn_o), 32'd1);
    wait_idle("mrst_run_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
